// File: rtl/wash_pkg.sv
// Purpose: shared types and constants for the wash cycle scheduler.
//   - wash_state_e : controller state encoding
//   - PROG_*       : program select codes
//   - wash_ticks / spin_ticks : per-program durations in Ticks
package wash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_FILL  = 3'd2,
    ST_WASH  = 3'd3,
    ST_SPIN  = 3'd4,
    ST_FAULT = 3'd5
  } wash_state_e;

  localparam int unsigned DUR_W = 8;

  localparam logic [1:0] PROG_QUICK    = 2'd0;
  localparam logic [1:0] PROG_NORMAL   = 2'd1;
  localparam logic [1:0] PROG_HEAVY    = 2'd2;
  localparam logic [1:0] PROG_DELICATE = 2'd3;

  // Wash phase length per program.
  function automatic logic [DUR_W-1:0] wash_ticks(input logic [1:0] prog);
    logic [DUR_W-1:0] d;
    case (prog)
      PROG_QUICK:    d = 8'd20;
      PROG_NORMAL:   d = 8'd60;
      PROG_HEAVY:    d = 8'd120;
      PROG_DELICATE: d = 8'd40;
      default:       d = 8'd0;
    endcase
    return d;
  endfunction

  // Spin phase length per program; Delicate has no spin time.
  function automatic logic [DUR_W-1:0] spin_ticks(input logic [1:0] prog);
    logic [DUR_W-1:0] d;
    case (prog)
      PROG_QUICK:    d = 8'd10;
      PROG_NORMAL:   d = 8'd30;
      PROG_HEAVY:    d = 8'd40;
      PROG_DELICATE: d = 8'd0;
      default:       d = 8'd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/tick_down_counter.sv
// Purpose: loadable down-counter stepped by a Tick enable, saturating at 0.
// Ports:
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_clear         : force count to 0 (highest priority after reset)
//   i_load/i_load_val : load a new count; a Tick in the same cycle is ignored
//   i_tick          : decrement enable
//   o_count         : registered count
//   o_zero_c        : combinational count==0 flag
module tick_down_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_tick,
  output logic [CNT_W-1:0] o_count,
  output logic             o_zero_c
);

  logic [CNT_W-1:0] r_count;

  // Load wins over Tick so the load cycle never consumes a Tick.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_count  = r_count;
  assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/wash_cycle_scheduler.sv
// Purpose: sequences fill / wash / spin phases of a washer, timing each
//   phase in Ticks and flagging a stuck fill with a sticky Fault.
// Ports:
//   Clock, Reset    : clock, synchronous active-high reset
//   Tick            : time-base enable
//   Start, Program  : start request (IDLE only) and program select
//   Abort           : cancel to IDLE from any state
//   Fill/Wash/Spin_Active : washer phase indications
//   Cycle_Timeout, Spin_Timeout : one-cycle completion pulses
//   Fault           : fill watchdog expired (sticky)
//   Busy            : not in IDLE
//   Remaining       : current countdown value
module wash_cycle_scheduler
  import wash_pkg::*;
#(
  parameter int unsigned FILL_LIMIT = 50,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Tick,
  input  logic             Start,
  input  logic [1:0]       Program,
  input  logic             Abort,
  input  logic             Fill_Active,
  input  logic             Wash_Active,
  input  logic             Spin_Active,
  output logic             Cycle_Timeout,
  output logic             Spin_Timeout,
  output logic             Fault,
  output logic             Busy,
  output logic [CNT_W-1:0] Remaining
);

  wash_state_e      r_state;
  wash_state_e      w_state_nxt;
  logic [1:0]       r_prog;
  logic [1:0]       w_prog_nxt;
  logic             r_cyc_to;
  logic             r_spin_to;
  logic             r_fault;
  logic             r_busy;
  logic             w_cyc_to;
  logic             w_spin_to;
  logic             w_load;
  logic             w_clear;
  logic             w_count_en;
  logic             w_zero;
  logic [CNT_W-1:0] w_load_val;
  logic [CNT_W-1:0] w_count;

  // Counting only runs while a timed phase is active.
  assign w_count_en = Tick && ((r_state == ST_FILL) || (r_state == ST_WASH) ||
                               (r_state == ST_SPIN));

  tick_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .i_clk      (Clock),
    .i_rst      (Reset),
    .i_clear    (w_clear),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_tick     (w_count_en),
    .o_count    (w_count),
    .o_zero_c   (w_zero)
  );

  // State, latched program and output registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= ST_IDLE;
      r_prog    <= 2'd0;
      r_cyc_to  <= 1'b0;
      r_spin_to <= 1'b0;
      r_fault   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_prog    <= w_prog_nxt;
      r_cyc_to  <= w_cyc_to;
      r_spin_to <= w_spin_to;
      r_fault   <= (w_state_nxt == ST_FAULT);
      r_busy    <= (w_state_nxt != ST_IDLE);
    end
  end

  // Next-state, counter control and pulse decode.
  always_comb begin
    w_state_nxt = r_state;
    w_prog_nxt  = r_prog;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_clear     = 1'b0;
    w_cyc_to    = 1'b0;
    w_spin_to   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          w_prog_nxt  = Program;
          w_state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (Spin_Active) begin
          w_state_nxt = ST_SPIN;
          w_load      = 1'b1;
          w_load_val  = CNT_W'(spin_ticks(r_prog));
        end else if (Wash_Active) begin
          w_state_nxt = ST_WASH;
          w_load      = 1'b1;
          w_load_val  = CNT_W'(wash_ticks(r_prog));
        end else if (Fill_Active) begin
          w_state_nxt = ST_FILL;
          w_load      = 1'b1;
          w_load_val  = CNT_W'(FILL_LIMIT);
        end
      end
      // A dropped fill is a normal completion even if the watchdog just hit 0.
      ST_FILL: begin
        if (!Fill_Active) begin
          w_state_nxt = ST_ARMED;
        end else if (w_zero) begin
          w_state_nxt = ST_FAULT;
        end
      end
      ST_WASH: begin
        if (w_zero) begin
          w_cyc_to    = 1'b1;
          w_state_nxt = ST_ARMED;
        end else if (!Wash_Active) begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_SPIN: begin
        if (w_zero) begin
          w_spin_to   = 1'b1;
          w_state_nxt = ST_IDLE;
          w_clear     = 1'b1;
        end else if (!Spin_Active) begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_FAULT: begin
        w_state_nxt = ST_FAULT;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_clear     = 1'b1;
      end
    endcase

    // Abort overrides everything, including a pulse due this cycle.
    if (Abort) begin
      w_state_nxt = ST_IDLE;
      w_load      = 1'b0;
      w_clear     = 1'b1;
      w_cyc_to    = 1'b0;
      w_spin_to   = 1'b0;
    end
  end

  assign Cycle_Timeout = r_cyc_to;
  assign Spin_Timeout  = r_spin_to;
  assign Fault         = r_fault;
  assign Busy          = r_busy;
  assign Remaining     = w_count;

endmodule

// File: doc/wash_cycle_scheduler.md
WASH_CYCLE_SCHEDULER -- requirements
Module: wash_cycle_scheduler

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset, with ports named Clock and Reset.
REQ-002 Port list, one per line (name  direction  width  meaning), SHALL be:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- Tick  in  1  one-cycle time-base enable; the unit of all durations.
- Start  in  1  begin a program; sampled only in IDLE.
- Program  in  2  program select; latched on an accepted Start.
- Abort  in  1  cancel the current program.
- Fill_Active  in  1  washer is in its fill phase.
- Wash_Active  in  1  washer is in its wash phase.
- Spin_Active  in  1  washer is in its spin phase.
- Cycle_Timeout  out  1  one-cycle pulse; wash duration elapsed.
- Spin_Timeout  out  1  one-cycle pulse; spin duration elapsed.
- Fault  out  1  sticky fill-watchdog expiry.
- Busy  out  1  high whenever the state is not IDLE.
- Remaining  out  8  current countdown value.
REQ-003 Parameters, one per line (name, default, meaning), SHALL be:
- FILL_LIMIT, 50, fill watchdog length in Ticks.
- CNT_W, 8, countdown counter width.

Function
REQ-004 Program table SHALL be (wash/spin, in Ticks): 0 Quick 20/10; 1 Normal 60/30; 2 Heavy 120/40; 3 Delicate 40/0.
REQ-005 States SHALL be IDLE, ARMED, FILL, WASH, SPIN and FAULT.
REQ-006 IDLE: Start=1 SHALL latch Program and move to ARMED; Program changes while Busy SHALL be ignored.
REQ-007 ARMED: an active input SHALL move to its matching state and load the counter, with priority Spin_Active > Wash_Active > Fill_Active.
REQ-008 Load values SHALL be: FILL loads FILL_LIMIT; WASH loads the wash duration; SPIN loads the spin duration.
REQ-009 A Tick in the load cycle SHALL be ignored; after that, each Tick SHALL decrement the counter, which saturates at 0.
REQ-010 WASH: on the first cycle with counter==0, the block SHALL drive Cycle_Timeout=1 for exactly one cycle and move to ARMED.
REQ-011 SPIN: on the first cycle with counter==0, the block SHALL drive Spin_Timeout=1 for exactly one cycle and move to IDLE.
REQ-012 A duration of 0 SHALL produce its pulse on the cycle after entry.
REQ-013 FILL: if Fill_Active drops before the counter reaches 0, the block SHALL return to ARMED with no Fault.
REQ-014 FILL: if the counter reaches 0 while Fill_Active=1, the block SHALL move to FAULT and set Fault=1.
REQ-015 WASH or SPIN: if the matching Active input drops before the counter reaches 0, the block SHALL return to ARMED with no pulse.
REQ-016 Abort=1 in any state SHALL move to IDLE on the next edge, clear Fault and Remaining, and suppress any pulse due that cycle.
REQ-017 FAULT SHALL be left only by Abort or Reset.
REQ-018 All outputs SHALL be registered; Remaining SHALL equal the counter value, and 0 in IDLE.

Reset
REQ-019 Reset=1 SHALL force IDLE, set every output to 0 and set the latched program to 0.
REQ-020 Reset SHALL take priority over Abort and Start.
REQ-021 Reset mid-countdown SHALL suppress the pending pulse.

Structure
REQ-022 Package wash_pkg SHALL hold the state enum, the program duration table, and the program-code constants.
REQ-023 One sub-module, tick_down_counter, SHALL implement load/Tick/zero-flag behaviour with CNT_W width.
REQ-024 The top level SHALL hold only the FSM and the output registers.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Program=0, Start, then Wash_Active held and Tick every cycle -> Cycle_Timeout is one cycle wide, 21 cycles after the load edge.
- Program=3, Spin_Active -> Spin_Timeout on the cycle after entry, then Busy=0.
- Fill_Active held for 50 Ticks -> Fault=1 and stays 1; a later Abort -> Fault=0 and IDLE.
- Program=2 with Wash_Active dropped at Remaining=70 -> no Cycle_Timeout; state ARMED.
- Spin_Active and Wash_Active asserted together in ARMED -> SPIN entered with Remaining=spin value.
- Reset asserted at Remaining=5 in WASH -> all outputs 0 and no pulse afterwards.
